// File: rtl/filter_wr_generator.sv
// Filter buffer write generator: turns a stream of filter words into circular
// buffer writes and tracks how many complete filters are waiting for the reader.
module filter_wr_generator #(
  parameter int HEIGHT    = 16,
  parameter int WIDTH     = 8,
  parameter int ADD_WIDTH = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADD_WIDTH:0]   filter_size,
  input  logic [7:0]           num_filters,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 filter_release,
  output logic                 filter_wen,
  output logic [ADD_WIDTH-1:0] filter_waddr,
  output logic [WIDTH-1:0]     filter_wdata,
  output logic                 filter_avail,
  output logic                 load_done
);

  localparam logic [ADD_WIDTH:0] DEPTH = (ADD_WIDTH+1)'(HEIGHT);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e                 state_q, state_d;
  logic [ADD_WIDTH:0]     size_q, size_d;
  logic [7:0]             total_q, total_d;
  logic [ADD_WIDTH-1:0]   idx_q, idx_d;
  logic [7:0]             fcnt_q, fcnt_d;
  logic [ADD_WIDTH-1:0]   head_q, head_d;
  logic [ADD_WIDTH:0]     occ_q, occ_d;
  logic [ADD_WIDTH:0]     cnt_q, cnt_d;
  logic                   wen_q, wen_d;
  logic [ADD_WIDTH-1:0]   waddr_q, waddr_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;

  logic                   legal_start, accept, rel, last_word, last_filter, complete;
  logic [ADD_WIDTH:0]     addr_sum, addr_wrap, head_sum, head_wrap;

  assign din_ready    = (state_q == LOAD) && (occ_q < DEPTH);
  assign filter_wen   = wen_q;
  assign filter_waddr = waddr_q;
  assign filter_wdata = wdata_q;
  assign filter_avail = (cnt_q != '0);
  assign load_done    = (state_q == DONE);

  always_comb begin
    legal_start = start && (state_q != LOAD) && (filter_size != '0) &&
                  (filter_size <= DEPTH) && (num_filters != 8'd0);
    accept      = din_valid && din_ready;
    // A release with nothing stored is dropped so count/occupancy never underflow.
    rel         = filter_release && (cnt_q != '0);
    last_word   = ({1'b0, idx_q} == (size_q - 1'b1));
    last_filter = ((fcnt_q + 8'd1) == total_q);
    complete    = accept && last_word;
    // Operands are below 2*HEIGHT, so one conditional subtract is a full mod.
    addr_sum    = {1'b0, head_q} + {1'b0, idx_q};
    addr_wrap   = (addr_sum >= DEPTH) ? addr_sum - DEPTH : addr_sum;
    head_sum    = {1'b0, head_q} + size_q;
    head_wrap   = (head_sum >= DEPTH) ? head_sum - DEPTH : head_sum;
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    total_d = total_q;
    idx_d   = idx_q;
    fcnt_d  = fcnt_q;
    head_d  = head_q;
    occ_d   = occ_q;
    cnt_d   = cnt_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    if (legal_start) begin
      // Head and occupancy survive a new job: stored filters are still unread.
      state_d = LOAD;
      size_d  = filter_size;
      total_d = num_filters;
      idx_d   = '0;
      fcnt_d  = '0;
    end else if (accept) begin
      wen_d   = 1'b1;
      waddr_d = addr_wrap[ADD_WIDTH-1:0];
      wdata_d = din;
      if (last_word) begin
        idx_d  = '0;
        head_d = head_wrap[ADD_WIDTH-1:0];
        fcnt_d = fcnt_q + 8'd1;
        if (last_filter) state_d = DONE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (accept) occ_d = occ_d + 1'b1;
    if (rel)    occ_d = occ_d - size_q;

    case ({complete, rel})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      size_q  <= '0;
      total_q <= '0;
      idx_q   <= '0;
      fcnt_q  <= '0;
      head_q  <= '0;
      occ_q   <= '0;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      total_q <= total_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      head_q  <= head_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_filter_wr_generator.sv
// Directed bench for filter_wr_generator (HEIGHT=16, WIDTH=8); expected values
// are hand-derived per scenario.
module tb_filter_wr_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] filter_size = '0;
  logic [7:0] num_filters = '0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       filter_release = 1'b0;
  logic       filter_wen;
  logic [3:0] filter_waddr;
  logic [7:0] filter_wdata;
  logic       filter_avail;
  logic       load_done;

  int nchk = 0;
  int npass = 0;

  filter_wr_generator #(.HEIGHT(16), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .filter_size(filter_size),
    .num_filters(num_filters), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .filter_release(filter_release),
    .filter_wen(filter_wen), .filter_waddr(filter_waddr),
    .filter_wdata(filter_wdata), .filter_avail(filter_avail),
    .load_done(load_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    nchk++; if ({din_ready, filter_wen, filter_waddr, filter_wdata, filter_avail, load_done} !== 16'h0)
      $display("FAIL reset_outputs: got %h exp 0", {din_ready, filter_wen, filter_waddr, filter_wdata, filter_avail, load_done}); else npass++;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; filter_size = 5'd8; num_filters = 8'd2;
    tick();
    start = 1'b0;
    nchk++; if (din_ready !== 1'b1) $display("FAIL b2b_ready: got %b exp 1", din_ready); else npass++;
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b1; din = 8'h30 + 8'(i);
      tick();
      nchk++; if (filter_wen !== 1'b1 || filter_waddr !== 4'(i) || filter_wdata !== 8'h30 + 8'(i))
        $display("FAIL b2b_write%0d: got wen=%b addr=%0d data=%h exp wen=1 addr=%0d data=%h",
                 i, filter_wen, filter_waddr, filter_wdata, i, 8'h30 + 8'(i)); else npass++;
      nchk++; if (filter_avail !== (i >= 7)) $display("FAIL b2b_avail%0d: got %b exp %b", i, filter_avail, i >= 7); else npass++;
      nchk++; if (load_done !== (i == 15)) $display("FAIL b2b_done%0d: got %b exp %b", i, load_done, i == 15); else npass++;
    end
    din_valid = 1'b0;
    tick();
    nchk++; if (filter_wen !== 1'b0 || filter_waddr !== 4'd15) $display("FAIL b2b_hold: got wen=%b addr=%0d exp wen=0 addr=15", filter_wen, filter_waddr); else npass++;
    filter_release = 1'b1;
    tick(); tick();
    filter_release = 1'b0;
    nchk++; if (filter_avail !== 1'b0 || dut.occ_q !== 5'd0) $display("FAIL b2b_drain: got avail=%b occ=%0d exp avail=0 occ=0", filter_avail, dut.occ_q); else npass++;
  endtask

  task automatic test_full();
    start = 1'b1; filter_size = 5'd8; num_filters = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b1; din = 8'h50 + 8'(i);
      tick();
    end
    nchk++; if (din_ready !== 1'b0 || load_done !== 1'b0) $display("FAIL full_stall: got ready=%b done=%b exp ready=0 done=0", din_ready, load_done); else npass++;
    din = 8'h77;
    tick();
    nchk++; if (filter_wen !== 1'b0) $display("FAIL full_no_write: got wen=%b exp 0", filter_wen); else npass++;
    filter_release = 1'b1;
    tick();
    filter_release = 1'b0;
    nchk++; if (din_ready !== 1'b1) $display("FAIL full_resume: got ready=%b exp 1", din_ready); else npass++;
    tick();
    nchk++; if (filter_wen !== 1'b1 || filter_waddr !== 4'd0 || filter_wdata !== 8'h77)
      $display("FAIL full_wrap: got wen=%b addr=%0d data=%h exp wen=1 addr=0 data=77", filter_wen, filter_waddr, filter_wdata); else npass++;
    for (int i = 1; i < 8; i++) begin
      din = 8'h77 + 8'(i);
      tick();
    end
    din_valid = 1'b0;
    nchk++; if (load_done !== 1'b1 || filter_waddr !== 4'd7) $display("FAIL full_done: got done=%b addr=%0d exp done=1 addr=7", load_done, filter_waddr); else npass++;
    filter_release = 1'b1;
    tick(); tick();
    filter_release = 1'b0;
    nchk++; if (dut.cnt_q !== 5'd0 || dut.occ_q !== 5'd0) $display("FAIL full_drain: got cnt=%0d occ=%0d exp 0 0", dut.cnt_q, dut.occ_q); else npass++;
  endtask

  task automatic test_coincident();
    start = 1'b1; filter_size = 5'd4; num_filters = 8'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      din_valid = 1'b1; din = 8'h90 + 8'(i);
      tick();
    end
    nchk++; if (dut.cnt_q !== 5'd1 || dut.occ_q !== 5'd7 || filter_waddr !== 4'd14)
      $display("FAIL coin_pre: got cnt=%0d occ=%0d addr=%0d exp 1 7 14", dut.cnt_q, dut.occ_q, filter_waddr); else npass++;
    din = 8'h97; filter_release = 1'b1;
    tick();
    din_valid = 1'b0; filter_release = 1'b0;
    nchk++; if (dut.cnt_q !== 5'd1 || dut.occ_q !== 5'd4) $display("FAIL coin_counts: got cnt=%0d occ=%0d exp cnt=1 occ=4", dut.cnt_q, dut.occ_q); else npass++;
    nchk++; if (filter_waddr !== 4'd15 || load_done !== 1'b1 || filter_avail !== 1'b1)
      $display("FAIL coin_state: got addr=%0d done=%b avail=%b exp 15 1 1", filter_waddr, load_done, filter_avail); else npass++;
    filter_release = 1'b1;
    tick();
    filter_release = 1'b0;
  endtask

  task automatic test_empty_release();
    filter_release = 1'b1;
    tick();
    filter_release = 1'b0;
    nchk++; if (dut.occ_q !== 5'd0 || dut.cnt_q !== 5'd0 || filter_avail !== 1'b0)
      $display("FAIL empty_release: got occ=%0d cnt=%0d avail=%b exp 0 0 0", dut.occ_q, dut.cnt_q, filter_avail); else npass++;
  endtask

  task automatic test_illegal_start();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    filter_release = 1'b1;
    tick();
    filter_release = 1'b0;
    nchk++; if (dut.occ_q !== 5'd0 || filter_avail !== 1'b0) $display("FAIL idle_release: got occ=%0d avail=%b exp 0 0", dut.occ_q, filter_avail); else npass++;
    start = 1'b1; filter_size = 5'd0; num_filters = 8'd1;
    tick();
    nchk++; if (din_ready !== 1'b0 || load_done !== 1'b0) $display("FAIL illegal_size0: got ready=%b done=%b exp 0 0", din_ready, load_done); else npass++;
    filter_size = 5'd17;
    tick();
    nchk++; if (din_ready !== 1'b0 || load_done !== 1'b0) $display("FAIL illegal_size17: got ready=%b done=%b exp 0 0", din_ready, load_done); else npass++;
    filter_size = 5'd4; num_filters = 8'd0;
    tick();
    start = 1'b0;
    nchk++; if (din_ready !== 1'b0 || load_done !== 1'b0) $display("FAIL illegal_num0: got ready=%b done=%b exp 0 0", din_ready, load_done); else npass++;
  endtask

  task automatic test_wrap();
    start = 1'b1; filter_size = 5'd3; num_filters = 8'd6;
    tick();
    start = 1'b0;
    for (int w = 0; w < 15; w++) begin
      din_valid = 1'b1; din = 8'hA0 + 8'(w);
      tick();
      nchk++; if (filter_waddr !== 4'(w)) $display("FAIL wrap_addr%0d: got %0d exp %0d", w, filter_waddr, w); else npass++;
      if (w % 3 == 2) begin
        nchk++; if (dut.head_q !== 4'(w + 1)) $display("FAIL wrap_head%0d: got %0d exp %0d", w, dut.head_q, w + 1); else npass++;
      end
    end
    din_valid = 1'b0; filter_release = 1'b1;
    tick(); tick();
    filter_release = 1'b0;
    nchk++; if (dut.occ_q !== 5'd9 || dut.head_q !== 4'd15) $display("FAIL wrap_pre6: got occ=%0d head=%0d exp 9 15", dut.occ_q, dut.head_q); else npass++;
    for (int k = 0; k < 3; k++) begin
      din_valid = 1'b1; din = 8'hB0 + 8'(k);
      tick();
      nchk++; if (filter_waddr !== 4'(15 + k)) $display("FAIL wrap_f6_%0d: got %0d exp %0d", k, filter_waddr, 4'(15 + k)); else npass++;
    end
    din_valid = 1'b0;
    nchk++; if (load_done !== 1'b1 || dut.head_q !== 4'd2) $display("FAIL wrap_done: got done=%b head=%0d exp 1 2", load_done, dut.head_q); else npass++;
    filter_release = 1'b1;
    tick(); tick(); tick();
    filter_release = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; filter_size = 5'd4; num_filters = 8'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din_valid = 1'b1; din = 8'hC0 + 8'(i);
      tick();
    end
    nchk++; if (filter_wen !== 1'b1 || filter_waddr !== 4'd3) $display("FAIL mid_pre: got wen=%b addr=%0d exp 1 3", filter_wen, filter_waddr); else npass++;
    #2 rst = 1'b0;
    #1;
    nchk++; if ({din_ready, filter_wen, filter_waddr, filter_wdata, filter_avail, load_done} !== 16'h0)
      $display("FAIL mid_async: got %h exp 0", {din_ready, filter_wen, filter_waddr, filter_wdata, filter_avail, load_done}); else npass++;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nchk++; if (filter_wen !== 1'b0 || din_ready !== 1'b0) $display("FAIL mid_quiet%0d: got wen=%b ready=%b exp 0 0", i, filter_wen, din_ready); else npass++;
    end
    din_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; din_valid = 1'b1; din = 8'h5A;
    tick();
    din_valid = 1'b0;
    nchk++; if (filter_wen !== 1'b1 || filter_waddr !== 4'd0 || filter_wdata !== 8'h5A)
      $display("FAIL mid_restart: got wen=%b addr=%0d data=%h exp 1 0 5a", filter_wen, filter_waddr, filter_wdata); else npass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_coincident();
    test_empty_release();
    test_illegal_start();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
